// File: rtl/i2s_dac_serializer.sv
// I2S DAC serializer: divides clk into bclk, frames a mono sample onto both channels.
// Define I2S_DAC_LEFT_JUSTIFIED_EN for left-justified framing instead of standard I2S.
module i2s_dac_serializer #(
    parameter int unsigned BCLK_DIV    = 16,
    parameter int unsigned SLOT_BITS   = 32,
    parameter int unsigned SAMPLE_BITS = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [SAMPLE_BITS-1:0] sample,
    output logic                   frame_tick,
    output logic                   bclk,
    output logic                   daclrck,
    output logic                   dacdat
);

    localparam int unsigned DW = $clog2(BCLK_DIV);
    localparam int unsigned BW = $clog2(2 * SLOT_BITS);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(2 * SLOT_BITS - 1);
    localparam logic [BW-1:0] SLOT     = BW'(SLOT_BITS);
    localparam logic [BW-1:0] SMP      = BW'(SAMPLE_BITS);

    logic [DW-1:0]          div_cnt_q, div_cnt_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic                   bclk_q, bclk_d;
    logic                   daclrck_q, daclrck_d;
    logic                   dacdat_q, dacdat_d;
    logic                   frame_tick_q, frame_tick_d;
    logic [SAMPLE_BITS-1:0] left_q, left_d;
    logic [SAMPLE_BITS-1:0] right_q, right_d;

    logic                   wrap, fall, latch, in_right, emit;
    logic [BW-1:0]          pos;
    logic [SAMPLE_BITS-1:0] left_v, right_v;

    always_comb begin
        div_cnt_d    = div_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        bclk_d       = bclk_q;
        daclrck_d    = daclrck_q;
        dacdat_d     = dacdat_q;
        frame_tick_d = 1'b0;
        left_d       = left_q;
        right_d      = right_q;
        latch        = 1'b0;
        in_right     = 1'b0;
        emit         = 1'b0;
        pos          = '0;
        left_v       = left_q;
        right_v      = right_q;

        wrap      = (div_cnt_q == DIV_LAST);
        fall      = wrap && bclk_q;
        div_cnt_d = wrap ? '0 : div_cnt_q + DW'(1);
        if (wrap) begin
            bclk_d = ~bclk_q;
        end

        if (fall) begin
            latch        = (bit_cnt_q == BIT_LAST);
            bit_cnt_d    = latch ? '0 : bit_cnt_q + BW'(1);
            frame_tick_d = latch;
            // The freshly latched word is used directly so the left-justified MSB
            // can leave in the latch cycle itself.
            left_v       = latch ? sample : left_q;
            right_v      = latch ? sample : right_q;
            left_d       = left_v;
            right_d      = right_v;
            in_right     = (bit_cnt_d >= SLOT);
            pos          = in_right ? bit_cnt_d - SLOT : bit_cnt_d;
`ifdef I2S_DAC_LEFT_JUSTIFIED_EN
            emit         = (pos < SMP);
            daclrck_d    = in_right;
`else
            emit         = (pos != '0) && (pos <= SMP);
            daclrck_d    = (bit_cnt_d >= SLOT - BW'(1)) && (bit_cnt_d <= BIT_LAST - BW'(1));
`endif
            dacdat_d     = 1'b0;
            if (emit) begin
                if (in_right) begin
                    dacdat_d = right_v[SAMPLE_BITS-1];
                    right_d  = right_v << 1;
                end else begin
                    dacdat_d = left_v[SAMPLE_BITS-1];
                    left_d   = left_v << 1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q    <= '0;
            bit_cnt_q    <= BIT_LAST;
            bclk_q       <= 1'b0;
            daclrck_q    <= 1'b0;
            dacdat_q     <= 1'b0;
            frame_tick_q <= 1'b0;
            left_q       <= '0;
            right_q      <= '0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            bclk_q       <= bclk_d;
            daclrck_q    <= daclrck_d;
            dacdat_q     <= dacdat_d;
            frame_tick_q <= frame_tick_d;
            left_q       <= left_d;
            right_q      <= right_d;
        end
    end

    assign frame_tick = frame_tick_q;
    assign bclk       = bclk_q;
    assign daclrck    = daclrck_q;
    assign dacdat     = dacdat_q;

endmodule

// File: tb/tb_i2s_dac_serializer.sv
// Bench for i2s_dac_serializer: time-based reference model plus a frame scoreboard.
// Follows I2S_DAC_LEFT_JUSTIFIED_EN in the same way as the design.
module tb_i2s_dac_serializer;

    localparam int D    = 2;
    localparam int D16  = 16;
    localparam int S    = 32;
    localparam int SB   = 24;
`ifdef I2S_DAC_LEFT_JUSTIFIED_EN
    localparam int LAST_P = SB - 1;
`else
    localparam int LAST_P = SB;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [SB-1:0] sample = 24'hA5F00F;
    logic          frame_tick, bclk, daclrck, dacdat;
    logic [SB-1:0] sample16 = 24'h00FFFF;
    logic          frame_tick16, bclk16, daclrck16, dacdat16;

    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    i2s_dac_serializer #(.BCLK_DIV(D), .SLOT_BITS(S), .SAMPLE_BITS(SB)) u_dut (
        .clk(clk), .reset(reset), .sample(sample), .frame_tick(frame_tick),
        .bclk(bclk), .daclrck(daclrck), .dacdat(dacdat)
    );

    i2s_dac_serializer #(.BCLK_DIV(D16), .SLOT_BITS(S), .SAMPLE_BITS(SB)) u_dut16 (
        .clk(clk), .reset(reset), .sample(sample16), .frame_tick(frame_tick16),
        .bclk(bclk16), .daclrck(daclrck16), .dacdat(dacdat16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_dl(input int n);
`ifdef I2S_DAC_LEFT_JUSTIFIED_EN
        return n >= S;
`else
        return (n >= S - 1) && (n <= 2 * S - 2);
`endif
    endfunction

    function automatic logic exp_dd(input int n, input logic [SB-1:0] v);
        int p;
        p = n % S;
`ifdef I2S_DAC_LEFT_JUSTIFIED_EN
        return (p < SB) ? v[SB-1-p] : 1'b0;
`else
        return (p >= 1 && p <= SB) ? v[SB-p] : 1'b0;
`endif
    endfunction

    function automatic bit in_data(input int p);
        return (p <= LAST_P) && (p >= LAST_P - SB + 1);
    endfunction

    // Reference model: outputs are a closed-form function of clocks since reset release.
    int unsigned   m_k = 0;
    int            m_n = 2 * S - 1;
    logic [SB-1:0] m_val = '0;
    logic [SB-1:0] exp_q[$];
    logic [SB-1:0] acc = '0;

    always @(posedge clk) begin
        int f, n, p;
        bit latch_e;
        #1;
        if (reset) begin
            m_k = 0;
            n = 2 * S - 1;
            exp_q.delete();
            chk("rst_bclk", {63'd0, bclk}, 64'd0);
            chk("rst_lrck", {63'd0, daclrck}, 64'd0);
            chk("rst_dat", {63'd0, dacdat}, 64'd0);
            chk("rst_tick", {63'd0, frame_tick}, 64'd0);
        end else begin
            m_k++;
            f = int'(m_k) / (2 * D);
            n = (f == 0) ? 2 * S - 1 : (f - 1) % (2 * S);
            latch_e = (int'(m_k) % (2 * D) == 0) && (n == 0);
            if (latch_e) begin
                m_val = sample;
                exp_q.push_back(sample);
                exp_q.push_back(sample);
            end
            chk("bclk", {63'd0, bclk}, {63'd0, ((int'(m_k) / D) % 2) == 1});
            chk("frame_tick", {63'd0, frame_tick}, {63'd0, latch_e});
            chk("daclrck", {63'd0, daclrck}, {63'd0, (f == 0) ? 1'b0 : exp_dl(n)});
            chk("dacdat", {63'd0, dacdat}, {63'd0, (f == 0) ? 1'b0 : exp_dd(n, m_val)});
            if (f >= 1 && (int'(m_k) % (2 * D) == D)) begin
                p = n % S;
                if (in_data(p)) begin
                    acc = {acc[SB-2:0], dacdat};
                    if (p == LAST_P) begin
                        if (exp_q.size() == 0) begin
                            chk("slot_queue_empty", 64'd0, 64'd1);
                        end else begin
                            chk(n < S ? "left_slot_word" : "right_slot_word",
                                {40'd0, acc}, {40'd0, exp_q.pop_front()});
                        end
                    end
                end
            end
        end
        m_n = n;
    end

    initial begin
        int got, cnt, prev, gap;
        logic [63:0] bits_dd, bits_dl, want_dd, want_dl;

        repeat (3) @(negedge clk);
        reset = 1'b0;

        got = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (frame_tick) begin
                got = c;
                chk("first_latch_lrck", {63'd0, daclrck}, 64'd0);
                chk("first_latch_dat", {63'd0, dacdat}, {63'd0, exp_dd(0, 24'hA5F00F)});
                break;
            end
        end
        chk("first_latch_delay", 64'(got), 64'(2 * D));

        repeat (600) @(negedge clk);

        sample = 24'h123456;
        got = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (frame_tick) begin got = 1; break; end
        end
        chk("tick_seen_123456", 64'(got), 64'd1);
        repeat (100) @(negedge clk);
        sample = 24'hFFFFFF;

        cnt = 0;
        for (int c = 0; c < 1024; c++) begin
            @(negedge clk);
            if (frame_tick) cnt++;
        end
        chk("ticks_per_1024clk", 64'(cnt), 64'd4);

        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            sample = 24'($urandom);
        end

        got = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (m_n == 40) begin got = 1; break; end
        end
        chk("reach_bitcnt40", 64'(got), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_bclk", {63'd0, bclk}, 64'd0);
        chk("midrst_lrck", {63'd0, daclrck}, 64'd0);
        chk("midrst_dat", {63'd0, dacdat}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sample = 24'h5A5A5A;
        got = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (frame_tick) begin got = c; break; end
        end
        chk("relatch_delay", 64'(got), 64'(2 * D));

        got = 0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (frame_tick16) begin got = 1; break; end
        end
        chk("div16_tick_seen", 64'(got), 64'd1);
        gap = -1;
        for (int c = 1; c <= 2200; c++) begin
            @(negedge clk);
            if (frame_tick16) begin gap = c; break; end
        end
        chk("div16_frame_period", 64'(gap), 64'(2 * D16 * 2 * S));

        bits_dd = '0; bits_dl = '0; want_dd = '0; want_dl = '0;
        cnt = 0; prev = bclk16; gap = -1; got = 0;
        for (int c = 1; c <= 2200 && cnt < 2 * S; c++) begin
            @(negedge clk);
            if (bclk16 && prev == 0) begin
                if (cnt == 1) got = c;
                if (cnt == 2) gap = c - got;
                bits_dd[cnt] = dacdat16;
                bits_dl[cnt] = daclrck16;
                want_dd[cnt] = exp_dd(cnt, 24'h00FFFF);
                want_dl[cnt] = exp_dl(cnt);
                cnt++;
            end
            prev = bclk16;
        end
        chk("div16_rise_count", 64'(cnt), 64'(2 * S));
        chk("div16_bclk_period", 64'(gap), 64'(2 * D16));
        chk("div16_frame_dat", bits_dd, want_dd);
        chk("div16_frame_lrck", bits_dl, want_dl);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2s_dac_serializer.md
Name: i2s_dac_serializer

Overview:
- Downstream stage of the tone sample generator. Takes its 24-bit parallel sample and serializes it to the board audio codec DAC port.
- Generates the bit clock (bclk), the left/right clock (daclrck) and the serial data (dacdat) from the system clock.
- Latches one sample per frame and sends it on both left and right channels (mono duplicate).
- Standard I2S framing by default; left-justified framing is a compile option.

Parameters:
- BCLK_DIV, 16: clk cycles per bclk half-period. Must be ≥2. bclk period = 2*BCLK_DIV clk.
- SLOT_BITS, 32: bclk periods per channel slot. Frame = 2*SLOT_BITS bclk periods.
- SAMPLE_BITS, 24: sample width. Must be ≤ SLOT_BITS-1.

Ports:
- clk, input, 1: system clock; all logic on posedge.
- reset, input, 1: synchronous, active-high reset.
- sample, input, SAMPLE_BITS: parallel sample from the generator; sampled only at the frame latch.
- frame_tick, output, 1: one-clk pulse in the cycle the sample is latched.
- bclk, output, 1: codec bit clock; codec samples dacdat on the bclk rising edge.
- daclrck, output, 1: channel select; 0 = left, 1 = right.
- dacdat, output, 1: serial data, MSB first.

Behaviour:
- Reset values (all registered, one cycle after reset asserted):
  - bclk=0, daclrck=0, dacdat=0, frame_tick=0.
  - div_cnt=0, bit_cnt=2*SLOT_BITS-1, shift registers=0.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1 and wraps.
  - On the wrap cycle bclk toggles.
  - A toggle 0→1 is a rise tick. A toggle 1→0 is a fall tick.
- bit_cnt (0..2*SLOT_BITS-1) advances only on fall ticks and wraps 2*SLOT_BITS-1 → 0.
- Frame latch, on the fall tick where bit_cnt wraps to 0:
  - Load the sample value present that cycle into the left and right shift registers.
  - frame_tick=1 for that cycle only.
- On every fall tick, daclrck, dacdat and the shift registers update in the same clk as bclk goes 0. All outputs are registered and glitch-free.
- I2S slot mapping. Let p = bit_cnt mod SLOT_BITS:
  - daclrck=1 for bit_cnt in SLOT_BITS-1..2*SLOT_BITS-2; otherwise 0. daclrck therefore leads each slot by one bclk.
  - dacdat = sample bit (SAMPLE_BITS-p) for p in 1..SAMPLE_BITS.
  - dacdat=0 for p=0 and for p > SAMPLE_BITS.
- The left slot carries the latched value on bit_cnt 0..SLOT_BITS-1. The right slot carries the same latched value on bit_cnt SLOT_BITS..2*SLOT_BITS-1.
- The sample input may change at any clk. Only the value at the latch cycle is transmitted; no tearing within a frame.
- First frame after reset release:
  - First rise tick at the BCLK_DIV-th clk after reset release.
  - First fall tick at the 2*BCLK_DIV-th clk; it is the frame latch.
- Reset mid-frame: the frame is aborted and outputs return to reset values next cycle. No partial-frame completion.
- Defaults at 50 MHz clk: bclk 1.5625 MHz, frame rate 24.414 kHz.

Optional Feature:
- Macro: I2S_DAC_LEFT_JUSTIFIED_EN.
- Defined (left-justified framing):
  - daclrck=1 exactly for bit_cnt in SLOT_BITS..2*SLOT_BITS-1.
  - dacdat = sample bit (SAMPLE_BITS-1-p) for p in 0..SAMPLE_BITS-1; otherwise 0.
  - The MSB appears in the latch cycle, taken directly from the latched input.
- Undefined: I2S mapping as above. The latch point and frame_tick are identical in both modes.

Test Plan (BCLK_DIV=2, SLOT_BITS=32, SAMPLE_BITS=24 unless noted):
- Reset held 3 clk, then released → bclk toggles every 2 clk; first frame_tick at the 4th clk after release; daclrck=0 and dacdat=0 at that cycle.
- sample=24'hA5F00F held → on each rise tick, the left slot reads bits p=1..24 as A5F00F MSB first, p=0 and p=25..31 read 0; the right slot reads identically; daclrck rises at bit_cnt 31 and falls at bit_cnt 63.
- sample changes 24'h123456→24'hFFFFFF mid-frame → the current frame still sends 123456 on both slots; the next frame sends FFFFFF; exactly one frame_tick per 256 clk.
- Reset asserted at bit_cnt 40 → next cycle bclk=0, daclrck=0, dacdat=0; the frame restarts with a latch 4 clk after release.
- I2S_DAC_LEFT_JUSTIFIED_EN defined, sample=24'h800001 → dacdat=1 at p=0 (latch cycle) and at p=23, 0 elsewhere; daclrck high exactly for bit_cnt 32..63.
- BCLK_DIV=16 build, sample=24'h00FFFF held → bclk period 32 clk; frame_tick period 2048 clk; frame decodes to 00FFFF.
